// File: rtl/uart_pkg.sv
// Definitions shared by the UART receiver and transmitter: FSM state encoding,
// parity mode codes and the default oversampling ratio.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam logic [1:0] PAR_NONE     = 2'b00;
    localparam logic [1:0] PAR_ODD      = 2'b01;
    localparam logic [1:0] PAR_EVEN     = 2'b10;
    localparam logic [1:0] PAR_NONE_ALT = 2'b11;

    localparam int OVERSAMPLE_DEF = 16;

    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_ODD) || (mode == PAR_EVEN);
    endfunction

endpackage

// File: rtl/rx_synchronizer.sv
// N-stage flop chain bringing the asynchronous rx line into the clk domain.
// Flops reset to 1 so the line looks idle while reset is held.
module rx_synchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_chain <= '1;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/receiver_fsm.sv
// UART receive engine: oversampled, mid-bit sampling of start/data/parity/stop
// fields with frame configuration latched at the start edge.
module receiver_fsm
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       sam_tick,
    input  logic [1:0] parity,
    input  logic       stop_bit,
    input  logic       bits_num,
    output logic [7:0] data_out,
    output logic       rx_done,
    output logic       parity_error,
    output logic       frame_error
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);

    uart_state_t r_state;
    logic [TW-1:0] r_tick;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic [1:0]    r_par_mode;
    logic          r_stop2;
    logic          r_bits8;
    logic          r_par_flag;
    logic          r_frame_flag;

    logic          w_rx_s;
    logic          w_at_sample;
    logic [7:0]    w_shift_next;
    logic          w_last_bit;
    logic          w_par_exp;
    logic          w_last_stop;

    rx_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (rx),
        .o_q   (w_rx_s)
    );

    assign w_at_sample  = sam_tick && (r_tick == LAST_TICK);
    assign w_shift_next = {w_rx_s, r_shift[7:1]};
    assign w_last_bit   = (r_bit == (r_bits8 ? 3'd7 : 3'd6));
    assign w_par_exp    = (r_par_mode == PAR_ODD) ? ~(^r_shift) : (^r_shift);
    assign w_last_stop  = (r_bit[0] == r_stop2);

    // rx_done is a valid-only strobe: one clk high per completed frame, with
    // data_out/parity_error/frame_error updated on that same edge and held until
    // the next strobe. There is no ready; the consumer must capture it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_tick       <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_par_mode   <= PAR_NONE;
            r_stop2      <= 1'b0;
            r_bits8      <= 1'b0;
            r_par_flag   <= 1'b0;
            r_frame_flag <= 1'b0;
            data_out     <= 8'h00;
            rx_done      <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        r_state      <= START;
                        r_tick       <= '0;
                        r_shift      <= '0;
                        r_par_mode   <= parity;
                        r_stop2      <= stop_bit;
                        r_bits8      <= bits_num;
                        r_par_flag   <= 1'b0;
                        r_frame_flag <= 1'b0;
                    end
                end
                START: begin
                    if (sam_tick) begin
                        if (r_tick == MID_TICK) begin
                            r_tick <= '0;
                            r_bit  <= '0;
                            r_state <= w_rx_s ? IDLE : DATA;
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (w_at_sample) begin
                        r_tick <= '0;
                        if (w_last_bit) begin
                            r_bit   <= '0;
                            // 7-bit words land in [7:1]; one more shift aligns bit 0
                            r_shift <= r_bits8 ? w_shift_next : {1'b0, w_shift_next[7:1]};
                            r_state <= parity_enabled(r_par_mode) ? PARITY : STOP;
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_shift <= w_shift_next;
                        end
                    end else if (sam_tick) begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                PARITY: begin
                    if (w_at_sample) begin
                        r_tick     <= '0;
                        r_par_flag <= (w_rx_s != w_par_exp);
                        r_state    <= STOP;
                    end else if (sam_tick) begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                STOP: begin
                    if (w_at_sample) begin
                        r_tick <= '0;
                        if (w_last_stop) begin
                            data_out     <= r_shift;
                            parity_error <= r_par_flag;
                            frame_error  <= r_frame_flag | ~w_rx_s;
                            rx_done      <= 1'b1;
                            r_state      <= IDLE;
                        end else begin
                            r_frame_flag <= r_frame_flag | ~w_rx_s;
                            r_bit        <= r_bit + 1'b1;
                        end
                    end else if (sam_tick) begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_receiver_fsm.sv
// Self-checking bench for receiver_fsm: directed scenarios plus randomized
// frames, checked against a frame-level reference model and expected queue.
module tb_receiver_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       sam_tick = 1'b0;
    logic [1:0] parity;
    logic       stop_bit;
    logic       bits_num;
    logic [7:0] data_out;
    logic       rx_done;
    logic       parity_error;
    logic       frame_error;

    int checks = 0;
    int errors = 0;
    int done_count = 0;
    int sent_count = 0;
    int tick_div = 1;
    int tick_cnt = 0;

    // expected entry: {frame_error, parity_error, data_out}
    logic [9:0] exp_q[$];
    logic [9:0] last_exp = 10'h000;

    receiver_fsm dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .sam_tick     (sam_tick),
        .parity       (parity),
        .stop_bit     (stop_bit),
        .bits_num     (bits_num),
        .data_out     (data_out),
        .rx_done      (rx_done),
        .parity_error (parity_error),
        .frame_error  (frame_error)
    );

    // clock and oversampling tick generation
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tick_cnt >= tick_div - 1) begin
            tick_cnt <= 0;
            sam_tick <= 1'b1;
        end else begin
            tick_cnt <= tick_cnt + 1;
            sam_tick <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // consumes n sam_tick edges, returning just after the last one
    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(negedge clk);
            while (sam_tick !== 1'b1) @(negedge clk);
            @(posedge clk);
            #1;
        end
    endtask

    // reference model + driver for one frame
    task automatic send_frame(input logic [7:0] d, input logic b8, input logic [1:0] pm,
                              input logic s2, input logic par_flip, input logic stop_low,
                              input logic scramble);
        logic [7:0] word;
        logic       pen;
        logic       pb;
        word = b8 ? d : {1'b0, d[6:0]};
        pen  = (pm == 2'b01) || (pm == 2'b10);
        pb   = (pm == 2'b10) ? ^word : ~(^word);
        exp_q.push_back({stop_low, pen & par_flip, word});
        sent_count++;
        parity   = pm;
        stop_bit = s2;
        bits_num = b8;
        rx = 1'b0;
        wait_ticks(16);
        if (scramble) begin
            parity   = 2'($urandom);
            stop_bit = 1'($urandom);
            bits_num = 1'($urandom);
        end
        for (int i = 0; i < (b8 ? 8 : 7); i++) begin
            rx = word[i];
            wait_ticks(16);
        end
        if (pen) begin
            rx = pb ^ par_flip;
            wait_ticks(16);
        end
        if (stop_low) begin
            // low across the sample point, high again before a restart could qualify
            rx = 1'b0;
            wait_ticks(12);
            rx = 1'b1;
            wait_ticks(4);
        end else begin
            rx = 1'b1;
            wait_ticks(16);
        end
        if (s2) begin
            rx = 1'b1;
            wait_ticks(16);
        end
    endtask

    // scoreboard: every rx_done pulse pops one expected frame
    initial begin
        logic       prev_done;
        logic [9:0] e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_done === 1'b1) begin
                done_count++;
                chk("done_width", 32'(prev_done), 32'd0);
                checks++;
                assert (exp_q.size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_done observed=pulse expected=none data=0x%0h", data_out);
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("data_out", 32'(data_out), 32'(e[7:0]));
                    chk("parity_error", 32'(parity_error), 32'(e[8]));
                    chk("frame_error", 32'(frame_error), 32'(e[9]));
                    last_exp = e;
                end
            end
            prev_done = rx_done;
        end
    end

    initial begin
        int n;
        reset    = 1'b1;
        rx       = 1'b1;
        parity   = 2'b00;
        stop_bit = 1'b0;
        bits_num = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data", 32'(data_out), 32'h00);
        chk("rst_done", 32'(rx_done), 32'd0);
        chk("rst_perr", 32'(parity_error), 32'd0);
        chk("rst_ferr", 32'(frame_error), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        wait_ticks(20);

        // 8N1
        send_frame(8'hA5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_ticks(16);
        chk("done_8n1", 32'(done_count), 32'(sent_count));

        // 7E2 clean then parity bit flipped
        send_frame(8'h55, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h55, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);

        // 8O1 with 0x00: parity bit 0 is wrong, 1 is right
        send_frame(8'h00, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h00, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);

        // framing error then clean frame
        send_frame(8'h3C, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h81, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_ticks(16);
        chk("done_directed", 32'(done_count), 32'(sent_count));

        // glitch on the start bit
        n = done_count;
        rx = 1'b0;
        wait_ticks(4);
        rx = 1'b1;
        wait_ticks(32);
        chk("glitch_no_done", 32'(done_count), 32'(n));
        chk("glitch_data", 32'(data_out), 32'(last_exp[7:0]));
        chk("glitch_perr", 32'(parity_error), 32'(last_exp[8]));
        chk("glitch_ferr", 32'(frame_error), 32'(last_exp[9]));

        // reset in the middle of the data field of an 0xFF frame
        n = done_count;
        parity = 2'b00; stop_bit = 1'b0; bits_num = 1'b1;
        rx = 1'b0;
        wait_ticks(16);
        rx = 1'b1;
        wait_ticks(48);
        reset = 1'b1;
        last_exp = 10'h000;
        repeat (3) @(negedge clk);
        chk("abort_data", 32'(data_out), 32'(last_exp[7:0]));
        chk("abort_flags", 32'({frame_error, parity_error}), 32'(last_exp[9:8]));
        @(posedge clk); #1;
        reset = 1'b0;
        wait_ticks(200);
        chk("abort_no_done", 32'(done_count), 32'(n));

        send_frame(8'h12, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        // back-to-back, no idle gap
        send_frame(8'h01, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h02, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_ticks(16);
        chk("done_b2b", 32'(done_count), 32'(sent_count));

        // randomized frames, config scrambled mid-frame
        for (int k = 0; k < 16; k++) begin
            wait_ticks($urandom_range(0, 20));
            tick_div = $urandom_range(1, 3);
            send_frame(8'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                       1'($urandom), ($urandom_range(0, 3) == 0), 1'b1);
        end

        n = 0;
        while (exp_q.size() > 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        wait_ticks(32);
        chk("done_total", 32'(done_count), 32'(sent_count));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/receiver_fsm.md
Name: receiver_fsm

Overview:
UART receive engine, the serial-in counterpart of the transmitter FSM. It shares the baud tick generator and the same runtime frame configuration: 7/8 data bits, none/even/odd parity, 1/2 stop bits, LSB first, idle-high line. It oversamples rx at 16 sam_tick per bit, mid-bit samples each field, and delivers a parallel byte with a one-cycle rx_done pulse plus parity/framing status to the host-side FIFO or register block.

Parameters:
OVERSAMPLE, 16, sam_tick pulses per bit period; mid-bit point is OVERSAMPLE/2-1.
SYNC_STAGES, 2, flip-flop stages on rx before use; minimum 2.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
rx  input  1  serial line, idle high, asynchronous to clk
sam_tick  input  1  one-clk-wide oversampling enable, 16x baud
parity  input  2  2'b00/2'b11 none, 2'b10 even, 2'b01 odd
stop_bit  input  1  0: one stop bit, 1: two stop bits
bits_num  input  1  0: 7 data bits, 1: 8 data bits
data_out  output  8  last received word; 7-bit mode zero-extends (bit 7 = 0)
rx_done  output  1  one-clk pulse when a frame completes
parity_error  output  1  parity mismatch in last frame
frame_error  output  1  a sampled stop bit was low in last frame

Behaviour:
- Reset (async, active-high): state=IDLE, counters=0, shift register=0, data_out=8'h00, rx_done=0, parity_error=0, frame_error=0. Synchronizer flops reset to 1. Reset mid-frame aborts the frame silently, with no rx_done.
- rx_s is the synchronized rx. All decisions use rx_s and advance only on clk edges where sam_tick=1, except the IDLE exit.
- Config (parity, stop_bit, bits_num) is latched on the IDLE->START transition and held for the whole frame. Mid-frame config changes are ignored.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: when rx_s=0, go to START with tick counter=0. No sam_tick is needed for this transition.
- START: on each sam_tick, count. At counter=7 (mid start bit):
  - If rx_s=0, set counter=0, bit counter=0 and go to DATA.
  - If rx_s=1, treat it as a glitch and return to IDLE with no outputs changed.
- DATA: sample rx_s at counter=15 (16 ticks after the mid-start point) and shift it into the MSB of the shift register (right shift).
  - After 7 or 8 bits per the latched bits_num, go to PARITY if parity is 2'b01 or 2'b10, else go to STOP.
  - In 7-bit mode the word is right-shifted once more so bit 0 is the first received bit and bit 7 is 0.
- PARITY: sample at counter=15.
  - Even: expected bit = XOR of the received data bits.
  - Odd: expected bit = inverted XOR.
  - Mismatch sets an internal parity flag.
- STOP: sample at counter=15 for each stop bit (1 or 2). Any low sample sets an internal frame flag.
  - On the last stop sample: data_out <= word, parity_error <= parity flag, frame_error <= frame flag, rx_done=1 for exactly one clk, state -> IDLE.
  - No wait for the line to reach full idle; a following start edge is accepted immediately.
- Status and data hold until the next rx_done. Flags from the previous frame are not sticky; each frame overwrites them.
- A frame_error frame (including rx stuck low, i.e. break) still completes and pulses rx_done. After a break, IDLE immediately re-enters START; that frame also ends with frame_error if the line stays low.
- sam_tick absent: the FSM holds state indefinitely, with no timeout.
- Latency: rx_done asserts 1 clk after the sam_tick edge that samples the final stop bit.
- Widths:
  - Tick counter 4 bits, wraps 15->0 within bits.
  - Bit counter 3 bits plus terminal compare; no overflow is possible.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings IDLE..STOP, shared with the transmitter;
  - parity mode constants PAR_NONE=2'b00, PAR_ODD=2'b01, PAR_EVEN=2'b10, PAR_NONE_ALT=2'b11;
  - the OVERSAMPLE default.
- One sub-module is natural: rx_synchronizer, an N-stage flop chain with reset value 1 and parameter SYNC_STAGES.

Test Plan:
1. 8N1 (bits_num=1, parity=00, stop_bit=0), sam_tick every clk, send 8'hA5 -> one rx_done pulse, data_out=8'hA5, parity_error=0, frame_error=0.
2. 7E2 (bits_num=0, parity=10, stop_bit=1), send 7'h55 with parity bit 0 -> data_out=8'h55, no errors; resend 7'h55 with parity bit 1 -> parity_error=1, data_out=8'h55.
3. 8O1 (parity=01), send 8'h00 with parity bit 0 -> parity_error=1; send 8'h00 with parity bit 1 -> parity_error=0.
4. 8N1, send 8'h3C with the stop bit driven low -> rx_done pulses, data_out=8'h3C, frame_error=1; the next clean frame 8'h81 -> frame_error=0.
5. Glitch: rx low for 4 sam_ticks then high -> FSM returns to IDLE, no rx_done, outputs unchanged.
6. Assert reset during DATA of frame 8'hFF, release, then send 8'h12 -> no rx_done for the aborted frame; rx_done with data_out=8'h12. Back-to-back frames 8'h01 and 8'h02 with no idle gap -> two rx_done pulses, in order.
